// File: rtl/apb_req_master.sv
// Bridges a valid/ready request stream onto an APB4 master port, returning
// read data and an error flag on a valid/ready response stream.
module apb_req_master #(
  parameter  int ADDR_WIDTH     = 32,
  parameter  int DATA_WIDTH     = 32,
  parameter  int TIMEOUT_CYCLES = 256,
  localparam int STRB_WIDTH     = (DATA_WIDTH + 7) / 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic                  req_write_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  input  logic [STRB_WIDTH-1:0] req_strb_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [DATA_WIDTH-1:0] rsp_rdata_o,
  output logic                  rsp_err_o,
  output logic [ADDR_WIDTH-1:0] paddr_o,
  output logic                  psel_o,
  output logic                  penable_o,
  output logic                  pwrite_o,
  output logic [DATA_WIDTH-1:0] pwdata_o,
  output logic [STRB_WIDTH-1:0] pstrb_o,
  input  logic                  pready_i,
  input  logic [DATA_WIDTH-1:0] prdata_i,
  input  logic                  pslverr_i
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETUP  = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;
  localparam logic [1:0] RESP   = 2'd3;

  localparam int              CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam bit              TO_EN    = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  logic [1:0]            state_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  write_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [STRB_WIDTH-1:0] strb_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  err_q;
  logic [CNT_W-1:0]      cnt_q;
  logic                  timeout_hit;

  // Last permitted wait cycle: abort unless the slave answers in this one.
  assign timeout_hit = TO_EN && (cnt_q == CNT_LAST);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; the datapath is reset too, as outputs read 0.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      strb_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid_i) begin
            addr_q  <= req_addr_i;
            write_q <= req_write_i;
            wdata_q <= req_write_i ? req_wdata_i : '0;
            strb_q  <= req_write_i ? req_strb_i  : '0;
            state_q <= SETUP;
          end
        end
        SETUP: begin
          cnt_q   <= '0;
          state_q <= ACCESS;
        end
        ACCESS: begin
          if (pready_i) begin
            rdata_q <= (!write_q && !pslverr_i) ? prdata_i : '0;
            err_q   <= pslverr_i;
            state_q <= RESP;
          end else begin
            if (cnt_q != CNT_MAX) cnt_q <= cnt_q + 1'b1;
            if (timeout_hit) begin
              rdata_q <= '0;
              err_q   <= 1'b1;
              state_q <= RESP;
            end
          end
        end
        RESP: begin
          if (rsp_ready_i) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready_o = (state_q == IDLE);
  assign psel_o      = (state_q == SETUP) || (state_q == ACCESS);
  assign penable_o   = (state_q == ACCESS);
  assign rsp_valid_o = (state_q == RESP);
  assign rsp_rdata_o = rdata_q;
  assign rsp_err_o   = err_q;
  assign paddr_o     = addr_q;
  assign pwrite_o    = write_q;
  assign pwdata_o    = wdata_q;
  assign pstrb_o     = strb_q;

endmodule
